// File: rtl/instruction_prefetch_queue.sv
// Fetch-side prefetch queue: owns the fetch PC, issues one imem read per cycle,
// buffers returned instructions with their PCs, and hands them to IF.
module instruction_prefetch_queue #(
  parameter int DEPTH      = 4,
  parameter int PC_WIDTH   = 12,
  parameter int INST_WIDTH = 19
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [PC_WIDTH-1:0]   imem_addr,
  output logic                  imem_rd_en,
  input  logic [INST_WIDTH-1:0] imem_data,
  output logic [INST_WIDTH-1:0] inst_out,
  output logic [PC_WIDTH-1:0]   inst_pc_plus1,
  output logic                  inst_valid,
  input  logic                  inst_ready,
  input  logic                  redirect,
  input  logic [PC_WIDTH-1:0]   redirect_pc,
  input  logic                  halt,
  output logic [2:0]            queue_count
);

  localparam int AW  = $clog2(DEPTH);
  localparam int CW  = $clog2(DEPTH) + 1;
  localparam int CW1 = CW + 1;

  logic [PC_WIDTH-1:0]   fetch_pc;
  logic [PC_WIDTH-1:0]   inflight_pc;
  logic [INST_WIDTH-1:0] inst_mem [DEPTH];
  logic [PC_WIDTH-1:0]   pc_mem   [DEPTH];
  logic [AW-1:0]         rd_ptr;
  logic [AW-1:0]         wr_ptr;
  logic [CW-1:0]         count;
  logic [CW1-1:0]        committed;
  logic                  inflight;
  logic                  halted;
  logic                  push;
  logic                  pop;

  // Reserve a slot for the outstanding read; a same-cycle pop is not credited.
  assign committed  = CW1'(count) + CW1'(inflight);
  assign imem_rd_en = !rst && !halted && !halt && !redirect
                      && (committed < CW1'(DEPTH));
  assign imem_addr  = fetch_pc;

  assign inst_valid = (count != '0);
  assign push       = inflight && !redirect;
  assign pop        = inst_valid && inst_ready && !redirect;

  assign inst_out      = inst_valid ? inst_mem[rd_ptr] : '0;
  assign inst_pc_plus1 = inst_valid ? pc_mem[rd_ptr] + PC_WIDTH'(1) : '0;
  assign queue_count   = 3'(count);

  always_ff @(posedge clk) begin
    if (!rst && push) begin
      inst_mem[wr_ptr] <= imem_data;
      pc_mem[wr_ptr]   <= inflight_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc    <= '0;
      inflight_pc <= '0;
      inflight    <= 1'b0;
      halted      <= 1'b0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
    end else begin
      if (halt) halted <= 1'b1;
      if (redirect) begin
        fetch_pc <= redirect_pc;
        inflight <= 1'b0;
        rd_ptr   <= '0;
        wr_ptr   <= '0;
        count    <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop)  rd_ptr <= rd_ptr + AW'(1);
        count    <= count + CW'(push) - CW'(pop);
        inflight <= imem_rd_en;
        if (imem_rd_en) begin
          fetch_pc    <= fetch_pc + PC_WIDTH'(1);
          inflight_pc <= fetch_pc;
        end
      end
    end
  end

endmodule

// File: tb/tb_instruction_prefetch_queue.sv
// Bench for instruction_prefetch_queue: directed scenarios plus a random
// phase, with a scoreboard of the sequential instruction stream.
module tb_instruction_prefetch_queue;

  localparam int DEPTH = 4;
  localparam int PW    = 12;
  localparam int IW    = 19;

  logic          clk = 1'b0;
  logic          rst;
  logic [PW-1:0] imem_addr;
  logic          imem_rd_en;
  logic [IW-1:0] imem_data;
  logic [IW-1:0] inst_out;
  logic [PW-1:0] inst_pc_plus1;
  logic          inst_valid;
  logic          inst_ready;
  logic          redirect;
  logic [PW-1:0] redirect_pc;
  logic          halt;
  logic [2:0]    queue_count;

  int compared   = 0;
  int mismatched = 0;

  typedef struct packed {
    logic [IW-1:0] inst;
    logic [PW-1:0] pcp1;
  } exp_t;

  exp_t exp_q[$];
  bit   halted_m = 1'b0;

  instruction_prefetch_queue #(
    .DEPTH(DEPTH), .PC_WIDTH(PW), .INST_WIDTH(IW)
  ) dut (
    .clk(clk), .rst(rst),
    .imem_addr(imem_addr), .imem_rd_en(imem_rd_en),
    .imem_data(imem_data),
    .inst_out(inst_out), .inst_pc_plus1(inst_pc_plus1),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .halt(halt), .queue_count(queue_count)
  );

  always #5 clk = ~clk;

  function automatic logic [IW-1:0] inst_of(input logic [PW-1:0] a);
    logic [6:0] h;
    h = 7'(a * 7 + 3);
    return {h, a};
  endfunction

  // Synchronous memory: data the cycle after the read, junk otherwise.
  always @(posedge clk)
    imem_data <= imem_rd_en ? inst_of(imem_addr) : IW'($urandom);

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // The IF side must see the instruction stream starting at the target.
  task automatic load(input logic [PW-1:0] start);
    logic [PW-1:0] a;
    exp_t e;
    exp_q.delete();
    a = start;
    for (int i = 0; i < 512; i++) begin
      e.inst = inst_of(a);
      e.pcp1 = a + PW'(1);
      exp_q.push_back(e);
      a = a + PW'(1);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      check("rd_en_in_reset", 32'(imem_rd_en), 32'd0);
    end else begin
      check("count_bound", 32'(queue_count <= 3'(DEPTH)), 32'd1);
      check("valid_vs_count", 32'(inst_valid), 32'(queue_count != 3'd0));
      if (!inst_valid) begin
        check("nop_out", 32'(inst_out), 32'd0);
        check("nop_pc1", 32'(inst_pc_plus1), 32'd0);
      end
      if (halted_m) check("rd_en_halted", 32'(imem_rd_en), 32'd0);
      if (inst_valid && inst_ready && !redirect) begin
        if (exp_q.size() == 0) begin
          check("sb_underflow", 32'(inst_pc_plus1), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("sb_inst", 32'(inst_out), 32'(e.inst));
          check("sb_pc1", 32'(inst_pc_plus1), 32'(e.pcp1));
        end
      end
    end
  end

  initial begin
    int hcnt;
    int r;
    logic [PW-1:0] rp;
    rst = 1'b1;
    inst_ready = 1'b0;
    redirect = 1'b0;
    redirect_pc = '0;
    halt = 1'b0;
    repeat (2) tick();
    check("rst_count", 32'(queue_count), 32'd0);
    check("rst_valid", 32'(inst_valid), 32'd0);
    check("rst_out", 32'(inst_out), 32'd0);
    check("rst_pc1", 32'(inst_pc_plus1), 32'd0);
    check("rst_addr", 32'(imem_addr), 32'd0);
    check("rst_rd_en", 32'(imem_rd_en), 32'd0);

    // Stream from 0.
    rst = 1'b0;
    inst_ready = 1'b1;
    load('0);
    #1;
    check("c0_rd_en", 32'(imem_rd_en), 32'd1);
    check("c0_addr", 32'(imem_addr), 32'd0);
    tick();
    check("c1_valid", 32'(inst_valid), 32'd0);
    check("c1_addr", 32'(imem_addr), 32'd1);
    tick();
    check("c2_valid", 32'(inst_valid), 32'd1);
    check("c2_out", 32'(inst_out), 32'(inst_of(12'h000)));
    check("c2_pc1", 32'(inst_pc_plus1), 32'd1);
    for (int i = 0; i < 8; i++) begin
      tick();
      check("stream_valid", 32'(inst_valid), 32'd1);
    end

    // Backpressure.
    inst_ready = 1'b0;
    repeat (6) tick();
    check("bp_count", 32'(queue_count), 32'd4);
    check("bp_rd_en", 32'(imem_rd_en), 32'd0);
    inst_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      check("bp_release_valid", 32'(inst_valid), 32'd1);
    end

    // Redirect flush with a response in flight.
    redirect = 1'b1;
    redirect_pc = 12'h123;
    load(12'h123);
    #1;
    check("redir_rd_en", 32'(imem_rd_en), 32'd0);
    tick();
    redirect = 1'b0;
    #1;
    check("redir_n1_valid", 32'(inst_valid), 32'd0);
    check("redir_n1_out", 32'(inst_out), 32'd0);
    check("redir_n1_addr", 32'(imem_addr), 32'h123);
    check("redir_n1_rd_en", 32'(imem_rd_en), 32'd1);
    tick();
    check("redir_n2_valid", 32'(inst_valid), 32'd0);
    tick();
    check("redir_n3_out", 32'(inst_out), 32'(inst_of(12'h123)));
    check("redir_n3_pc1", 32'(inst_pc_plus1), 32'h124);
    repeat (4) tick();

    // Wrap-around.
    redirect = 1'b1;
    redirect_pc = 12'hFFE;
    load(12'hFFE);
    tick();
    redirect = 1'b0;
    repeat (2) tick();
    check("wrap_out0", 32'(inst_out), 32'(inst_of(12'hFFE)));
    check("wrap_pc0", 32'(inst_pc_plus1), 32'hFFF);
    tick();
    check("wrap_out1", 32'(inst_out), 32'(inst_of(12'hFFF)));
    check("wrap_pc1", 32'(inst_pc_plus1), 32'h000);
    tick();
    check("wrap_out2", 32'(inst_out), 32'(inst_of(12'h000)));
    check("wrap_pc2", 32'(inst_pc_plus1), 32'h001);
    repeat (3) tick();

    // Halt with two entries queued and one in flight.
    inst_ready = 1'b0;
    tick();
    halt = 1'b1;
    halted_m = 1'b1;
    #1;
    check("halt_h_count", 32'(queue_count), 32'd2);
    check("halt_h_rd_en", 32'(imem_rd_en), 32'd0);
    tick();
    halt = 1'b0;
    check("halt_h1_count", 32'(queue_count), 32'd3);
    inst_ready = 1'b1;
    repeat (3) tick();
    check("halt_drained", 32'(inst_valid), 32'd0);
    exp_q.delete();
    redirect = 1'b1;
    redirect_pc = 12'h050;
    tick();
    redirect = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("halt_redir_valid", 32'(inst_valid), 32'd0);
    end
    rst = 1'b1;
    halted_m = 1'b0;
    tick();
    rst = 1'b0;
    load('0);
    #1;
    check("halt_rst_rd_en", 32'(imem_rd_en), 32'd1);
    check("halt_rst_addr", 32'(imem_addr), 32'd0);
    repeat (5) tick();

    // Reset while full and stalled.
    inst_ready = 1'b0;
    repeat (6) tick();
    check("full_count", 32'(queue_count), 32'd4);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    load('0);
    #1;
    check("mid_rst_count", 32'(queue_count), 32'd0);
    check("mid_rst_valid", 32'(inst_valid), 32'd0);
    check("mid_rst_addr", 32'(imem_addr), 32'd0);
    check("mid_rst_rd_en", 32'(imem_rd_en), 32'd1);
    inst_ready = 1'b1;
    repeat (4) tick();

    // Random traffic.
    hcnt = 0;
    for (int i = 0; i < 1500; i++) begin
      rst = 1'b0;
      redirect = 1'b0;
      halt = 1'b0;
      r = $urandom_range(0, 199);
      if (halted_m) hcnt++;
      if ((halted_m && hcnt > 12) || r == 0) begin
        rst = 1'b1;
        halted_m = 1'b0;
        hcnt = 0;
        load('0);
      end else if (r < 8) begin
        rp = PW'($urandom);
        redirect = 1'b1;
        redirect_pc = rp;
        load(rp);
      end else if (r < 10 && !halted_m) begin
        halt = 1'b1;
        halted_m = 1'b1;
      end
      inst_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    rst = 1'b0;
    redirect = 1'b0;
    halt = 1'b0;
    inst_ready = 1'b1;
    repeat (10) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
